// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : Read-side drain controller. On an accepted start it issues
//               exactly burst_len reads to a 1-cycle-latency FIFO and
//               forwards the words, in order, onto a valid/ready stream
//               through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_re,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic w_start_ok;
  logic w_pop;
  logic w_push;
  logic w_room;
  logic w_re;
  logic w_last_pop;

  assign w_start_ok = start && (burst_len != '0);
  assign w_pop      = (r_occ != 2'd0) && m_ready;
  assign w_push     = r_inflight;
  // A word leaving this cycle frees its slot in time for the read issued now,
  // which is what keeps a full-rate stream at one word per cycle; occupancy
  // plus in-flight still never exceeds two after the edge.
  assign w_room     = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_re       = (r_state == S_READ) && !fifo_empty && (r_issued < r_len) && w_room;
  assign w_last_pop = w_pop && (r_rd_count == (r_len - C_ONE));

  assign fifo_re  = w_re;
  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf0;
  assign busy     = (r_state != S_IDLE);
  assign rd_count = r_rd_count;

  // State register.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and done pulse; done coincides with the final accepted word.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_READ;
      S_READ:  if (w_re && ((r_issued + C_ONE) == r_len)) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_last_pop) begin
                 done        = 1'b1;
                 w_state_nxt = S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst length latch plus issued/accepted counters.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_rd_count <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_re;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_len      <= burst_len;
        r_issued   <= '0;
        r_rd_count <= '0;
      end else begin
        if (w_re)  r_issued   <= r_issued + C_ONE;
        if (w_pop) r_rd_count <= r_rd_count + C_ONE;
      end
    end
  end

  // Skid buffer: r_buf0 is always the oldest entry and only moves on a pop.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_push) begin
        if (w_pop) begin
          if (r_occ == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end else begin
            r_buf0 <= fifo_dout;
          end
        end else if (r_occ == 2'd0) begin
          r_buf0 <= fifo_dout;
        end else begin
          r_buf1 <= fifo_dout;
        end
      end else if (w_pop) begin
        r_buf0 <= r_buf1;
      end
    end
  end

endmodule
`default_nettype wire
